// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and constants for the multiply/divide controller:
// FSM states, latched operation kinds, divider sizing and the divide-by-zero result.
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_MUL   = 3'd3,
    OP_DIV   = 3'd4,
    OP_DIVU  = 3'd5
  } op_e;

  localparam int DIV_ITERS = 32;
  localparam int DIV_CNT_W = $clog2(DIV_ITERS);

  // Divide by zero never traps; the quotient saturates and HI returns the dividend.
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_radix2.sv
// Iterative unsigned radix-2 restoring divider, one quotient bit per cycle.
// quotient/remainder show the final step's value in the cycle done is high.
module div_radix2
  import muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam logic [DIV_CNT_W-1:0] LAST_ITER = DIV_CNT_W'(DIV_ITERS - 1);

  logic [31:0]          rem_q, rem_d;
  logic [31:0]          quo_q, quo_d;
  logic [31:0]          dsr_q, dsr_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic                 busy_q, busy_d;

  logic [32:0] partial;
  logic [32:0] diff;
  logic        fits;
  logic [31:0] rem_step;
  logic [31:0] quo_step;

  // quo_q doubles as the dividend shift register: its MSB feeds the partial remainder.
  always_comb begin
    partial  = {rem_q, quo_q[31]};
    diff     = partial - {1'b0, dsr_q};
    fits     = ~diff[32];
    rem_step = fits ? diff[31:0] : partial[31:0];
    quo_step = {quo_q[30:0], fits};
  end

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (abort) begin
      busy_d = 1'b0;
    end else if (start) begin
      rem_d  = '0;
      quo_d  = dividend;
      dsr_d  = divisor;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = rem_step;
      quo_d = quo_step;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_ITER) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dsr_q  <= dsr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign done      = busy_q && (cnt_q == LAST_ITER);
  assign quotient  = quo_step;
  assign remainder = rem_step;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide unit for the EX stage: single-cycle multiplier, 32-cycle divider,
// sign fix-up, mthi/mtlo, and the pipeline stall/flush handshake.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic        is_mult,
  input  logic        is_multu,
  input  logic        is_div,
  input  logic        is_divu,
  input  logic        is_mul,
  input  logic        hi_wen,
  input  logic        lo_wen,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] result,
  output logic        result_valid
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        any_mul;
  logic        any_div;
  logic        idle_ok;
  logic        accept;
  logic        div_start;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_done;
  logic [31:0] div_quo;
  logic [31:0] div_rem;

  logic        mul_signed;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod_full;
  logic        div_signed;
  logic [31:0] quo_fixed;
  logic [31:0] rem_fixed;

  always_comb begin
    any_mul      = is_mult | is_multu | is_mul;
    any_div      = is_div | is_divu;
    idle_ok      = (state_q == ST_IDLE) && ex_valid && !flush;
    accept       = idle_ok && (any_mul || any_div);
    div_start    = accept && !any_mul && any_div;
    div_dividend = mag32(rs_data, is_div);
    div_divisor  = mag32(rt_data, is_div);
  end

  div_radix2 u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .abort     (flush),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Sign-extending to 64 bits first makes the truncated product correct for signed ops.
  always_comb begin
    mul_signed = (op_q == OP_MULT) || (op_q == OP_MUL);
    a_ext      = mul_signed ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    b_ext      = mul_signed ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    prod_full  = a_ext * b_ext;
    div_signed = (op_q == OP_DIV);
    quo_fixed  = neg_if(div_quo, div_signed && (a_q[31] ^ b_q[31]));
    rem_fixed  = neg_if(div_rem, div_signed && a_q[31]);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d = rs_data;
          b_d = rt_data;
          if (is_mult)       op_d = OP_MULT;
          else if (is_multu) op_d = OP_MULTU;
          else if (is_mul)   op_d = OP_MUL;
          else if (is_div)   op_d = OP_DIV;
          else               op_d = OP_DIVU;
          state_d = any_mul ? ST_MUL : ST_DIV;
        end else if (idle_ok) begin
          if (hi_wen) hi_d = rs_data;
          if (lo_wen) lo_d = rs_data;
        end
      end
      ST_MUL: begin
        prod_d  = prod_full;
        state_d = ST_DONE;
        if (op_q != OP_MUL) begin
          hi_d = prod_full[63:32];
          lo_d = prod_full[31:0];
        end
      end
      ST_DIV: begin
        if (div_done) begin
          state_d = ST_DONE;
          if (b_q == 32'd0) begin
            lo_d = DIV0_QUOTIENT;
            hi_d = a_q;
          end else begin
            lo_d = quo_fixed;
            hi_d = rem_fixed;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A flush cancels whatever is in flight, including a completing operation.
    if (flush) begin
      state_d = ST_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NONE;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign stall        = !flush && (accept || (state_q == ST_MUL) || (state_q == ST_DIV));
  assign result_valid = !flush && (state_q == ST_DONE);
  assign result       = ((state_q == ST_DONE) && (op_q == OP_MUL)) ? prod_q[31:0] : 32'd0;
  assign hi           = hi_q;
  assign lo           = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl with hand-computed HI/LO/result values.
module tb_muldiv_ctrl;

  logic        clk;
  logic        resetn;
  logic        ex_valid;
  logic        is_mult, is_multu, is_div, is_divu, is_mul;
  logic        hi_wen, lo_wen;
  logic [31:0] rs_data, rt_data;
  logic        flush;
  logic        stall;
  logic [31:0] hi, lo, result;
  logic        result_valid;

  int tests_run;
  int tests_failed;

  localparam logic [4:0] OP_MULT  = 5'b10000;
  localparam logic [4:0] OP_MULTU = 5'b01000;
  localparam logic [4:0] OP_DIV   = 5'b00100;
  localparam logic [4:0] OP_DIVU  = 5'b00010;
  localparam logic [4:0] OP_MUL   = 5'b00001;

  muldiv_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .ex_valid     (ex_valid),
    .is_mult      (is_mult),
    .is_multu     (is_multu),
    .is_div       (is_div),
    .is_divu      (is_divu),
    .is_mul       (is_mul),
    .hi_wen       (hi_wen),
    .lo_wen       (lo_wen),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .flush        (flush),
    .stall        (stall),
    .hi           (hi),
    .lo           (lo),
    .result       (result),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task clear_inputs;
    ex_valid = 1'b0;
    {is_mult, is_multu, is_div, is_divu, is_mul} = 5'b0;
    hi_wen  = 1'b0;
    lo_wen  = 1'b0;
    rs_data = 32'd0;
    rt_data = 32'd0;
    flush   = 1'b0;
  endtask

  task next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Issues one op and counts stall cycles; operands are scrambled after accept.
  // Returns in the first non-stalled cycle (DONE), inputs idle.
  task issue(input logic [4:0] op, input logic [31:0] rs, input logic [31:0] rt, output int n);
    next_cycle();
    ex_valid = 1'b1;
    {is_mult, is_multu, is_div, is_divu, is_mul} = op;
    rs_data = rs;
    rt_data = rt;
    n = 0;
    #1;
    while (stall === 1'b1 && n < 100) begin
      n++;
      next_cycle();
      clear_inputs();
      rs_data = ~rs;
      rt_data = rs ^ rt ^ 32'h5A5A_A5A5;
      #1;
    end
  endtask

  task move_to(input logic hw, input logic lw, input logic [31:0] v, input logic fl);
    next_cycle();
    ex_valid = 1'b1;
    hi_wen   = hw;
    lo_wen   = lw;
    rs_data  = v;
    flush    = fl;
    next_cycle();
    clear_inputs();
    #1;
  endtask

  task test_reset;
    resetn = 1'b1;
    clear_inputs();
    #1 resetn = 1'b0;
    #11;
    tests_run++; if (hi !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_hi: got %h expected %h", hi, 32'd0); end
    tests_run++; if (lo !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_lo: got %h expected %h", lo, 32'd0); end
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
    tests_run++; if (result_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rv: got %b expected 0", result_valid); end
    tests_run++; if (result !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_result: got %h expected 0", result); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task test_mult;
    int n;
    issue(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, n);
    tests_run++; if (n != 2) begin tests_failed++; $display("[TB] FAIL mult_stall: got %0d expected 2", n); end
    tests_run++; if (result_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL mult_done_rv: got %b expected 1", result_valid); end
    tests_run++; if (result !== 32'd0) begin tests_failed++; $display("[TB] FAIL mult_result: got %h expected 0", result); end
    tests_run++; if (hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("[TB] FAIL mult_hi: got %h expected FFFFFFFF", hi); end
    tests_run++; if (lo !== 32'hFFFF_FFFA) begin tests_failed++; $display("[TB] FAIL mult_lo: got %h expected FFFFFFFA", lo); end
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    tests_run++; if (hi !== 32'hFFFF_FFFE) begin tests_failed++; $display("[TB] FAIL multu_hi: got %h expected FFFFFFFE", hi); end
    tests_run++; if (lo !== 32'h0000_0001) begin tests_failed++; $display("[TB] FAIL multu_lo: got %h expected 00000001", lo); end
    issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    tests_run++; if (hi !== 32'h0000_0000) begin tests_failed++; $display("[TB] FAIL mult_neg_hi: got %h expected 00000000", hi); end
    tests_run++; if (lo !== 32'h0000_0001) begin tests_failed++; $display("[TB] FAIL mult_neg_lo: got %h expected 00000001", lo); end
  endtask

  task test_divide;
    int n;
    issue(OP_DIVU, 32'd100, 32'd7, n);
    tests_run++; if (n != 33) begin tests_failed++; $display("[TB] FAIL divu_stall: got %0d expected 33", n); end
    tests_run++; if (result_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL divu_done_rv: got %b expected 1", result_valid); end
    tests_run++; if (lo !== 32'd14) begin tests_failed++; $display("[TB] FAIL divu_lo: got %h expected %h", lo, 32'd14); end
    tests_run++; if (hi !== 32'd2) begin tests_failed++; $display("[TB] FAIL divu_hi: got %h expected %h", hi, 32'd2); end
    next_cycle();
    tests_run++; if (result_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL divu_idle_rv: got %b expected 0", result_valid); end
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, n);
    tests_run++; if (lo !== 32'hFFFF_FFFD) begin tests_failed++; $display("[TB] FAIL div_neg_lo: got %h expected FFFFFFFD", lo); end
    tests_run++; if (hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("[TB] FAIL div_neg_hi: got %h expected FFFFFFFF", hi); end
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
    tests_run++; if (lo !== 32'h8000_0000) begin tests_failed++; $display("[TB] FAIL div_ovf_lo: got %h expected 80000000", lo); end
    tests_run++; if (hi !== 32'h0000_0000) begin tests_failed++; $display("[TB] FAIL div_ovf_hi: got %h expected 00000000", hi); end
  endtask

  task test_div_zero;
    int n;
    issue(OP_DIV, 32'd5, 32'd0, n);
    tests_run++; if (n != 33) begin tests_failed++; $display("[TB] FAIL div0_stall: got %0d expected 33", n); end
    tests_run++; if (lo !== 32'hFFFF_FFFF) begin tests_failed++; $display("[TB] FAIL div0_lo: got %h expected FFFFFFFF", lo); end
    tests_run++; if (hi !== 32'd5) begin tests_failed++; $display("[TB] FAIL div0_hi: got %h expected 00000005", hi); end
    issue(OP_DIV, 32'hFFFF_FFFB, 32'd0, n);
    tests_run++; if (lo !== 32'hFFFF_FFFF) begin tests_failed++; $display("[TB] FAIL div0_neg_lo: got %h expected FFFFFFFF", lo); end
    tests_run++; if (hi !== 32'hFFFF_FFFB) begin tests_failed++; $display("[TB] FAIL div0_neg_hi: got %h expected FFFFFFFB", hi); end
    issue(OP_DIVU, 32'hFFFF_FFF0, 32'd0, n);
    tests_run++; if (lo !== 32'hFFFF_FFFF) begin tests_failed++; $display("[TB] FAIL divu0_lo: got %h expected FFFFFFFF", lo); end
    tests_run++; if (hi !== 32'hFFFF_FFF0) begin tests_failed++; $display("[TB] FAIL divu0_hi: got %h expected FFFFFFF0", hi); end
  endtask

  task test_mul_gpr;
    int n;
    move_to(1'b1, 1'b0, 32'h0000_00AA, 1'b0);
    move_to(1'b0, 1'b1, 32'h0000_00BB, 1'b0);
    issue(OP_MUL, 32'd6, 32'd7, n);
    tests_run++; if (n != 2) begin tests_failed++; $display("[TB] FAIL mul_stall: got %0d expected 2", n); end
    tests_run++; if (result_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL mul_rv: got %b expected 1", result_valid); end
    tests_run++; if (result !== 32'd42) begin tests_failed++; $display("[TB] FAIL mul_result: got %h expected %h", result, 32'd42); end
    tests_run++; if (hi !== 32'h0000_00AA) begin tests_failed++; $display("[TB] FAIL mul_hi_kept: got %h expected 000000AA", hi); end
    tests_run++; if (lo !== 32'h0000_00BB) begin tests_failed++; $display("[TB] FAIL mul_lo_kept: got %h expected 000000BB", lo); end
    move_to(1'b1, 1'b0, 32'h0000_1234, 1'b0);
    tests_run++; if (hi !== 32'h0000_1234) begin tests_failed++; $display("[TB] FAIL mthi_hi: got %h expected 00001234", hi); end
    tests_run++; if (lo !== 32'h0000_00BB) begin tests_failed++; $display("[TB] FAIL mthi_lo_kept: got %h expected 000000BB", lo); end
    move_to(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
    tests_run++; if (hi !== 32'h0000_1234) begin tests_failed++; $display("[TB] FAIL mthi_flush_hi: got %h expected 00001234", hi); end
    tests_run++; if (lo !== 32'h0000_00BB) begin tests_failed++; $display("[TB] FAIL mtlo_flush_lo: got %h expected 000000BB", lo); end
  endtask

  task test_flush;
    int n;
    int seen_rv;
    move_to(1'b1, 1'b0, 32'h11, 1'b0);
    move_to(1'b0, 1'b1, 32'h22, 1'b0);
    next_cycle();
    ex_valid = 1'b1; is_divu = 1'b1; rs_data = 32'd100; rt_data = 32'd7;
    #1;
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_accept_stall: got %b expected 1", stall); end
    repeat (10) begin next_cycle(); clear_inputs(); end
    #1;
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_div10_stall: got %b expected 1", stall); end
    flush = 1'b1;
    #1;
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_stall: got %b expected 0", stall); end
    tests_run++; if (result_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_rv: got %b expected 0", result_valid); end
    next_cycle();
    flush = 1'b0;
    #1;
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_idle_stall: got %b expected 0", stall); end
    seen_rv = 0;
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      if (result_valid === 1'b1 || stall === 1'b1) seen_rv++;
    end
    tests_run++; if (seen_rv != 0) begin tests_failed++; $display("[TB] FAIL flush_no_done: got %0d busy cycles expected 0", seen_rv); end
    tests_run++; if (hi !== 32'h11) begin tests_failed++; $display("[TB] FAIL flush_hi: got %h expected 00000011", hi); end
    tests_run++; if (lo !== 32'h22) begin tests_failed++; $display("[TB] FAIL flush_lo: got %h expected 00000022", lo); end
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'h10, n);
    tests_run++; if (n != 33) begin tests_failed++; $display("[TB] FAIL after_flush_stall: got %0d expected 33", n); end
    tests_run++; if (lo !== 32'h0FFF_FFFF) begin tests_failed++; $display("[TB] FAIL after_flush_lo: got %h expected 0FFFFFFF", lo); end
    tests_run++; if (hi !== 32'h0000_000F) begin tests_failed++; $display("[TB] FAIL after_flush_hi: got %h expected 0000000F", hi); end
  endtask

  task test_reset_mid;
    int n;
    next_cycle();
    ex_valid = 1'b1; is_divu = 1'b1; rs_data = 32'd100; rt_data = 32'd7;
    repeat (5) begin next_cycle(); clear_inputs(); end
    #2 resetn = 1'b0;
    #1;
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_stall: got %b expected 0", stall); end
    tests_run++; if (hi !== 32'd0) begin tests_failed++; $display("[TB] FAIL midrst_hi: got %h expected 0", hi); end
    tests_run++; if (lo !== 32'd0) begin tests_failed++; $display("[TB] FAIL midrst_lo: got %h expected 0", lo); end
    @(negedge clk);
    resetn = 1'b1;
    issue(OP_MULT, 32'd3, 32'd4, n);
    tests_run++; if (n != 2) begin tests_failed++; $display("[TB] FAIL postrst_stall: got %0d expected 2", n); end
    tests_run++; if (lo !== 32'd12) begin tests_failed++; $display("[TB] FAIL postrst_lo: got %h expected 0000000C", lo); end
    tests_run++; if (hi !== 32'd0) begin tests_failed++; $display("[TB] FAIL postrst_hi: got %h expected 0", hi); end
  endtask

  task test_flush_at_completion;
    next_cycle();
    ex_valid = 1'b1; is_divu = 1'b1; rs_data = 32'd100; rt_data = 32'd7;
    repeat (32) begin next_cycle(); clear_inputs(); end
    #1;
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL last_div_stall: got %b expected 1", stall); end
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    #1;
    tests_run++; if (result_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL cmpl_flush_rv: got %b expected 0", result_valid); end
    tests_run++; if (lo !== 32'd12) begin tests_failed++; $display("[TB] FAIL cmpl_flush_lo: got %h expected 0000000C", lo); end
    tests_run++; if (hi !== 32'd0) begin tests_failed++; $display("[TB] FAIL cmpl_flush_hi: got %h expected 0", hi); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_mult();
    test_divide();
    test_div_zero();
    test_mul_gpr();
    test_flush();
    test_reset_mid();
    test_flush_at_completion();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
